// File: rtl/lc3b_mem_sequencer.sv
// LC-3b memory-transaction sequencer: one request at a time, optional pointer fetch,
// byte-lane steering, response timeout with bounded retry and a give-up error flag.
module lc3b_mem_sequencer #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int TIMEOUT   = 255,
   parameter int MAX_RETRY = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic                   req_byte,
   input  logic                   req_indirect,
   input  logic [ADDR_W-1:0]      req_addr,
   input  logic [DATA_W-1:0]      req_wdata,
   output logic                   done_valid,
   output logic [DATA_W-1:0]      done_rdata,
   output logic                   done_error,
   output logic [ADDR_W-1:0]      mem_address,
   output logic                   mem_read,
   output logic                   mem_write,
   output logic [DATA_W/8-1:0]    mem_byte_enable,
   output logic [DATA_W-1:0]      mem_wdata,
   input  logic [DATA_W-1:0]      mem_rdata,
   input  logic                   mem_resp
);

   localparam int LANES = DATA_W / 8;
   localparam int LSB_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [ADDR_W-1:0] LSB_MASK = ADDR_W'(LANES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PTR,
      S_ACC,
      S_GAP,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic                r_write;
   logic                r_byte;
   logic                r_indirect;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [ADDR_W-1:0]   r_ptr;
   logic                r_in_ptr;
   logic [TMR_W-1:0]    r_timer;
   logic [RTY_W-1:0]    r_retry;

   logic                w_accept;
   logic                w_busy;
   logic                w_expire;
   logic                w_give_up;
   logic                w_write;
   logic                w_byte;
   logic                w_indirect;
   logic [ADDR_W-1:0]   w_addr;
   logic [DATA_W-1:0]   w_wdata;
   logic [ADDR_W-1:0]   w_ptr;
   logic [ADDR_W-1:0]   w_base;
   logic [ADDR_W-1:0]   w_acc_addr;
   logic [LSB_W-1:0]    w_lane;
   logic [LSB_W-1:0]    w_rd_lane;
   logic [DATA_W-1:0]   w_rd_shift;
   logic [DATA_W-1:0]   w_rd_byte;

   logic                w_req_ready_nxt;
   logic                w_done_valid_nxt;
   logic                w_done_error_nxt;
   logic [DATA_W-1:0]   w_done_rdata_nxt;
   logic [ADDR_W-1:0]   w_mem_address_nxt;
   logic                w_mem_read_nxt;
   logic                w_mem_write_nxt;
   logic [LANES-1:0]    w_mem_be_nxt;
   logic [DATA_W-1:0]   w_mem_wdata_nxt;

   assign w_accept  = (r_state == S_IDLE) && req_valid;
   assign w_busy    = (r_state == S_PTR) || (r_state == S_ACC);
   assign w_expire  = w_busy && !mem_resp && (r_timer == TMR_W'(TIMEOUT - 1));
   assign w_give_up = w_expire && (r_retry == RTY_W'(MAX_RETRY));

   // On the accept cycle the request has not been latched yet, so use the live inputs.
   assign w_write    = w_accept ? req_write    : r_write;
   assign w_byte     = w_accept ? req_byte     : r_byte;
   assign w_indirect = w_accept ? req_indirect : r_indirect;
   assign w_addr     = w_accept ? req_addr     : r_addr;
   assign w_wdata    = w_accept ? req_wdata    : r_wdata;

   assign w_ptr      = ((r_state == S_PTR) && mem_resp) ? ADDR_W'(mem_rdata) : r_ptr;
   assign w_base     = w_indirect ? w_ptr : w_addr;
   assign w_acc_addr = w_byte ? w_base : (w_base & ~LSB_MASK);
   assign w_lane     = LSB_W'(w_base & LSB_MASK);

   // Byte reads keep the lane bits in the address, so the lane comes from the live address.
   assign w_rd_lane  = LSB_W'(mem_address & LSB_MASK);
   assign w_rd_shift = mem_rdata >> {w_rd_lane, 3'b000};
   assign w_rd_byte  = DATA_W'(w_rd_shift[7:0]);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      // NOTE: default first so no branch leaves the next state unassigned and infers a latch.
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: if (req_valid) w_state_nxt = req_indirect ? S_PTR : S_ACC;
         S_PTR: begin
            if (mem_resp)      w_state_nxt = S_ACC;
            else if (w_expire) w_state_nxt = w_give_up ? S_DONE : S_GAP;
         end
         S_ACC: begin
            if (mem_resp)      w_state_nxt = S_DONE;
            else if (w_expire) w_state_nxt = w_give_up ? S_DONE : S_GAP;
         end
         S_GAP:   w_state_nxt = r_in_ptr ? S_PTR : S_ACC;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_write    <= 1'b0;
         r_byte     <= 1'b0;
         r_indirect <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_ptr      <= '0;
         r_in_ptr   <= 1'b0;
         r_timer    <= '0;
         r_retry    <= '0;
      end else begin
         if (w_accept) begin
            r_write    <= req_write;
            r_byte     <= req_byte;
            r_indirect <= req_indirect;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
         end
         if ((r_state == S_PTR) && mem_resp) r_ptr <= ADDR_W'(mem_rdata);
         if (w_state_nxt == S_PTR)      r_in_ptr <= 1'b1;
         else if (w_state_nxt == S_ACC) r_in_ptr <= 1'b0;
         // Timer restarts on every phase change, gap or completion.
         if (w_busy && !mem_resp && (w_state_nxt == r_state)) r_timer <= r_timer + 1'b1;
         else                                                r_timer <= '0;
         if (w_accept)                  r_retry <= '0;
         else if (w_state_nxt == S_GAP) r_retry <= r_retry + 1'b1;
      end
   end

   // Outputs are computed from the next state and registered, so strobes follow the state.
   always_comb begin
      w_req_ready_nxt   = (w_state_nxt == S_IDLE);
      w_done_valid_nxt  = 1'b0;
      w_done_error_nxt  = 1'b0;
      w_done_rdata_nxt  = '0;
      w_mem_address_nxt = mem_address;
      w_mem_read_nxt    = 1'b0;
      w_mem_write_nxt   = 1'b0;
      w_mem_be_nxt      = '1;
      w_mem_wdata_nxt   = mem_wdata;
      unique case (w_state_nxt)
         S_PTR: begin
            w_mem_read_nxt    = 1'b1;
            w_mem_address_nxt = w_addr & ~LSB_MASK;
         end
         S_ACC: begin
            w_mem_read_nxt    = !w_write;
            w_mem_write_nxt   = w_write;
            w_mem_address_nxt = w_acc_addr;
            if (w_write) begin
               w_mem_wdata_nxt = w_byte ? {LANES{w_wdata[7:0]}} : w_wdata;
               w_mem_be_nxt    = w_byte ? (LANES'(1) << w_lane) : '1;
            end
         end
         S_DONE: begin
            w_done_valid_nxt = 1'b1;
            w_done_error_nxt = w_give_up;
            if (!w_give_up && !r_write) w_done_rdata_nxt = r_byte ? w_rd_byte : mem_rdata;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_ready       <= 1'b1;
         done_valid      <= 1'b0;
         done_error      <= 1'b0;
         done_rdata      <= '0;
         mem_address     <= '0;
         mem_read        <= 1'b0;
         mem_write       <= 1'b0;
         mem_byte_enable <= '1;
         mem_wdata       <= '0;
      end else begin
         req_ready       <= w_req_ready_nxt;
         done_valid      <= w_done_valid_nxt;
         done_error      <= w_done_error_nxt;
         done_rdata      <= w_done_rdata_nxt;
         mem_address     <= w_mem_address_nxt;
         mem_read        <= w_mem_read_nxt;
         mem_write       <= w_mem_write_nxt;
         mem_byte_enable <= w_mem_be_nxt;
         mem_wdata       <= w_mem_wdata_nxt;
      end
   end

endmodule
